// File: rtl/digest_hex_tx.sv
// Digest byte to ASCII hex streamer: buffers bytes in a FIFO and emits two
// lowercase hex characters per byte, plus a newline after each digest.
module digest_hex_tx #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       dv_in,
    input  logic       data_end,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < W || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("digest_hex_tx: DEPTH must be a power of two and >= W");
    end

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_NL} state_t;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_end_q, hold_end_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      char_out_q, char_out_d;
    logic            char_valid_q, char_valid_d;

    logic [8:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [8:0]      mem_wdata;

    logic            push, pop, handshake, nonempty;
    logic [8:0]      head;
    logic [AW-1:0]   wptr_prev;

    assign head      = mem_q[rptr_q];
    assign wptr_prev = wptr_q - AW'(1);
    assign nonempty  = (count_q != '0);
    assign handshake = char_valid_q & char_ready;

    // Next-state, FIFO control and registered output values
    always_comb begin
        state_d      = state_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        hold_end_d   = hold_end_q;
        overflow_d   = overflow_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        pop          = 1'b0;
        push         = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wptr_q;
        mem_wdata    = {data_end, data_in};

        case (state_q)
            S_IDLE: begin
                if (nonempty) pop = 1'b1;
            end
            S_HI: begin
                if (handshake) begin
                    state_d    = S_LO;
                    char_out_d = hex(hold_q[3:0]);
                end
            end
            S_LO: begin
                if (handshake) begin
                    if (hold_end_q) begin
                        state_d    = S_NL;
                        char_out_d = 8'h0A;
                    end else if (nonempty) begin
                        pop = 1'b1;
                    end else begin
                        state_d      = S_IDLE;
                        char_valid_d = 1'b0;
                        char_out_d   = 8'h00;
                    end
                end
            end
            S_NL: begin
                if (handshake) begin
                    if (nonempty) begin
                        pop = 1'b1;
                    end else begin
                        state_d      = S_IDLE;
                        char_valid_d = 1'b0;
                        char_out_d   = 8'h00;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            hold_d       = head[7:0];
            hold_end_d   = head[8];
            state_d      = S_HI;
            char_valid_d = 1'b1;
            char_out_d   = hex(head[7:4]);
            rptr_d       = rptr_q + AW'(1);
        end

        // A refused byte still terminates its digest via the newest stored entry
        if (dv_in) begin
            if (count_q < CW'(DEPTH) || pop) begin
                push   = 1'b1;
                mem_we = 1'b1;
                wptr_d = wptr_q + AW'(1);
            end else begin
                overflow_d = 1'b1;
                if (data_end && nonempty) begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr_prev;
                    mem_wdata = {1'b1, mem_q[wptr_prev][7:0]};
                end
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            hold_end_q   <= 1'b0;
            overflow_q   <= 1'b0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            hold_end_q   <= hold_end_d;
            overflow_q   <= overflow_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign overflow   = overflow_q;
    assign busy       = nonempty | (state_q != S_IDLE);

endmodule

// File: tb/tb_digest_hex_tx.sv
// Directed self-checking bench for digest_hex_tx.
module tb_digest_hex_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       dv_in = 1'b0;
    logic       data_end = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_out;
    logic       char_valid;
    logic       busy;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] got[$];
    int got_cyc[$];
    logic [7:0] eb[$];

    digest_hex_tx #(.W(32), .DEPTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dv_in      (dv_in),
        .data_end   (data_end),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && char_valid && char_ready) begin
            got.push_back(char_out);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input int n, input logic [7:0] base, input bit end_last);
        for (int i = 0; i < n; i++) begin
            dv_in    = 1'b1;
            data_in  = base + 8'(i);
            data_end = end_last && (i == n - 1);
            tick();
        end
        dv_in    = 1'b0;
        data_end = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (n < budget) else begin
            n_err++;
            $error("FAIL %s_timeout: observed %0d cycles expected < %0d", tag, n, budget);
        end
    endtask

    // Expected characters: two lowercase hex digits per byte, then one newline
    task automatic check_stream(input string tag);
        string hx = "0123456789abcdef";
        logic [7:0] ec[$];
        int m;
        foreach (eb[i]) begin
            ec.push_back(8'(hx[int'(eb[i][7:4])]));
            ec.push_back(8'(hx[int'(eb[i][3:0])]));
        end
        ec.push_back(8'h0A);
        check({tag, "_len"}, 32'(got.size()), 32'(ec.size()));
        m = (got.size() < ec.size()) ? got.size() : ec.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_c%0d", tag, i), 32'(got[i]), 32'(ec[i]));
    endtask

    initial begin
        // Reset values
        #1;
        check("rst_valid", 32'(char_valid), 32'h0);
        check("rst_char", 32'(char_out), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-byte digest, latency and per-cycle characters
        char_ready = 1'b1;
        dv_in = 1'b1; data_in = 8'hA5; data_end = 1'b0;
        tick();
        check("a5_lat_valid", 32'(char_valid), 32'h0);
        check("a5_lat_busy", 32'(busy), 32'h1);
        data_in = 8'h0F; data_end = 1'b1;
        tick();
        dv_in = 1'b0; data_end = 1'b0;
        check("a5_valid", 32'(char_valid), 32'h1);
        check("a5_c0", 32'(char_out), 32'h61);
        tick(); check("a5_c1", 32'(char_out), 32'h35);
        tick(); check("a5_c2", 32'(char_out), 32'h30);
        tick(); check("a5_c3", 32'(char_out), 32'h66);
        tick(); check("a5_c4", 32'(char_out), 32'h0A);
        tick();
        check("a5_idle_valid", 32'(char_valid), 32'h0);
        check("a5_idle_char", 32'(char_out), 32'h00);
        check("a5_idle_busy", 32'(busy), 32'h0);

        // Full 32-byte digest at sustained ready
        got.delete(); got_cyc.delete();
        push_seq(32, 8'h00, 1'b1);
        drain("d32", 200);
        eb.delete();
        for (int i = 0; i < 32; i++) eb.push_back(8'(i));
        check_stream("d32");
        check("d32_ovf", 32'(overflow), 32'h0);
        if (got_cyc.size() == 65)
            check("d32_nobubble", 32'(got_cyc[64] - got_cyc[0]), 32'd64);

        // Stall during HI holds the character stable
        char_ready = 1'b0;
        got.delete();
        push_seq(1, 8'h3C, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_c%0d", i), {23'h0, char_valid, char_out}, {23'h0, 1'b1, 8'h33});
            tick();
        end
        char_ready = 1'b1;
        tick(); check("stall_lo", 32'(char_out), 32'h63);
        tick(); check("stall_nl", 32'(char_out), 32'h0A);
        tick(); check("stall_idle", 32'(char_valid), 32'h0);

        // Overflow: 34 bytes with sink stalled; hold plus 32 FIFO entries kept
        char_ready = 1'b0;
        got.delete();
        push_seq(34, 8'h00, 1'b1);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_busy", 32'(busy), 32'h1);
        char_ready = 1'b1;
        drain("ovf", 400);
        eb.delete();
        for (int i = 0; i < 33; i++) eb.push_back(8'(i));
        check_stream("ovf");
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Asynchronous reset mid-digest
        got.delete();
        push_seq(2, 8'hC0, 1'b1);
        tick();
        check("mid_valid_pre", 32'(char_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(char_valid), 32'h0);
        check("arst_char", 32'(char_out), 32'h00);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ovf", 32'(overflow), 32'h0);
        tick();
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 5; i++) tick();
        check("arst_quiet_valid", 32'(char_valid), 32'h0);
        check("arst_quiet_chars", 32'(got.size()), 32'h0);

        // Full FIFO accepts a byte in the same cycle as a pop
        char_ready = 1'b0;
        push_seq(33, 8'h00, 1'b0);
        check("fullpop_ovf_pre", 32'(overflow), 32'h0);
        got.delete();
        char_ready = 1'b1;
        tick();
        dv_in = 1'b1; data_in = 8'hEE; data_end = 1'b1;
        tick();
        dv_in = 1'b0; data_end = 1'b0;
        check("fullpop_ovf", 32'(overflow), 32'h0);
        drain("fullpop", 400);
        eb.delete();
        for (int i = 0; i < 33; i++) eb.push_back(8'(i));
        eb.push_back(8'hEE);
        check_stream("fullpop");
        check("fullpop_ovf_end", 32'(overflow), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
